// File: rtl/ascii_bcd_counter.sv
// ascii_bcd_counter: multi-digit decimal counter with ASCII digit outputs.
// A prescaler produces one count tick every TICK_DIV enabled clocks. Digits
// support clear, saturating parallel load and wrap detection for cascading.
// Optional feature macro: ASCII_BCD_COUNTER_DOWN_EN enables down counting
// through the 'up' input; without it the counter always counts up.
module ascii_bcd_counter #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 100000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_bcd,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   ascii_out,
  output logic                  tick_out,
  output logic                  wrap
);

  localparam int PW = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]         r_presc;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_tick;
  logic                  r_wrap;

  logic                  w_tick;
  logic [4*DIGITS-1:0]   w_inc;
  logic                  w_inc_cy;
  logic [4*DIGITS-1:0]   w_next;
  logic                  w_next_wrap;
  logic [4*DIGITS-1:0]   w_load_sat;

  // Clamp an out-of-range BCD nibble to 9.
  function automatic logic [3:0] sat9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  assign w_tick = en && (r_presc == PMAX);

  // Saturate every load nibble independently.
  always_comb begin
    w_load_sat = '0;
    for (int i = 0; i < DIGITS; i++)
      w_load_sat[4*i +: 4] = sat9(load_bcd[4*i +: 4]);
  end

  // Ripple increment; the final carry means every digit was 9.
  always_comb begin
    w_inc    = r_bcd;
    w_inc_cy = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_inc_cy) begin
        if (r_bcd[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          w_inc_cy        = 1'b0;
        end
      end
    end
  end

`ifdef ASCII_BCD_COUNTER_DOWN_EN
  logic [4*DIGITS-1:0]   w_dec;
  logic                  w_dec_bw;

  // Ripple decrement; the final borrow means every digit was 0.
  always_comb begin
    w_dec    = r_bcd;
    w_dec_bw = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_dec_bw) begin
        if (r_bcd[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
          w_dec_bw        = 1'b0;
        end
      end
    end
  end

  assign w_next      = up ? w_inc    : w_dec;
  assign w_next_wrap = up ? w_inc_cy : w_dec_bw;
`else
  // Direction input is kept on the port list but has no effect here.
  logic w_unused_up;
  assign w_unused_up = up;
  assign w_next      = w_inc;
  assign w_next_wrap = w_inc_cy;
`endif

  // Prescaler, digits and registered pulses: clear > load > tick > hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_bcd   <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (clear) begin
      r_presc <= '0;
      r_bcd   <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_presc <= '0;
      r_bcd   <= w_load_sat;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_bcd   <= w_next;
      r_tick  <= 1'b1;
      r_wrap  <= w_next_wrap;
    end else begin
      if (en)
        r_presc <= r_presc + PW'(1);
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end
  end

  // ASCII decode: '0' is 7'h30, so each digit is {3'b011, bcd}.
  always_comb begin
    ascii_out = '0;
    for (int i = 0; i < DIGITS; i++)
      ascii_out[7*i +: 7] = {3'b011, r_bcd[4*i +: 4]};
  end

  assign bcd_out  = r_bcd;
  assign tick_out = r_tick;
  assign wrap     = r_wrap;

endmodule

// File: doc/ascii_bcd_counter.md
# ascii_bcd_counter

Parametrised multi-digit decimal counter with ASCII-encoded digit outputs, driven by an internal prescaler tick. It generalises the two-digit 1 Hz ASCII counter in three ways: any digit count, a configurable tick divider, and run/load/clear/direction controls. It also provides a wrap pulse for cascading. It feeds display/UART text paths that consume 7-bit ASCII digits directly.

## Interface
- DIGITS, 2: number of decimal digits (≥1).
- TICK_DIV, 100000000: clk cycles per count tick (≥1); 100000000 gives 1 Hz at 100 MHz.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low freezes the prescaler and digits.
- up  in  1  direction: 1 = count up, 0 = count down (see Configuration).
- clear  in  1  synchronous clear of digits and prescaler.
- load  in  1  synchronous parallel load.
- load_bcd  in  4*DIGITS  BCD load value; digit i at [4i+3:4i], i=0 least significant.
- bcd_out  out  4*DIGITS  current count, BCD, same packing.
- ascii_out  out  7*DIGITS  current count as ASCII; digit i at [7i+6:7i], value 7'h30 + digit.
- tick_out  out  1  one-cycle pulse on each count tick.
- wrap  out  1  one-cycle pulse when the count wraps (all-9 to all-0, or all-0 to all-9).

## Operation
- Prescaler: register of width max(1, $clog2(TICK_DIV)), counting 0..TICK_DIV-1 while en=1, then returning to 0. The internal tick is true when en=1 and prescaler == TICK_DIV-1. With TICK_DIV=1 the tick is true on every enabled cycle.
- Priority at each edge: clear > load > tick > hold.
- clear: all digits go to 0 and the prescaler goes to 0. wrap and tick_out are 0 that cycle.
- load: each digit takes load_bcd; any nibble >9 is saturated to 9. The prescaler goes to 0, and no tick takes effect that cycle.
- Tick, up: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. If all digits are 9 the count becomes all-0 and wrap pulses.
- Tick, down: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. If all digits are 0 the count becomes all-9 and wrap pulses.
- en=0: prescaler and digits hold, no tick. clear and load still act.
- up is sampled only on the tick cycle; changing it between ticks has no other effect.
- bcd_out and ascii_out are combinational decodes of the digit registers. ascii_out[7i+6:7i] = {3'b011, digit_i}.

## Timing
- Reset (reset_n low, asynchronous) gives:
  - prescaler 0 and all digits 0;
  - ascii_out = 7'h30 on every digit, bcd_out = 0;
  - tick_out = 0, wrap = 0.
- Release of reset is synchronous to clk; the first tick occurs TICK_DIV enabled cycles after release.
- tick_out and wrap are registered. They are high for exactly the one cycle after the tick edge, coincident with the updated digits.
- Count latency: digits change on the clock edge that ends the tick cycle. Load and clear results are visible the cycle after assertion.
- Tick period with en held high: exactly TICK_DIV cycles. Deasserting en stretches the period by the number of disabled cycles; the prescaler value is retained, not reset.
- A clear or load asserted in the tick cycle suppresses that tick: no tick_out and no wrap.

## Configuration
- ASCII_BCD_COUNTER_DOWN_EN defined: the up input selects direction as described.
- Not defined: down-count logic is not compiled and the block always counts up. The up port remains on the interface but is ignored, so the port list is identical in both builds.

## Test plan
- Reset and prescale (DIGITS=2, TICK_DIV=4, en=1): hold reset_n low, then release.
  - While in reset: ascii_out = {7'h30,7'h30}.
  - tick_out pulses every 4 cycles.
  - After 10 ticks: bcd_out = 8'h10, ascii_out = {7'h31,7'h30}.
- Up wrap: load 8'h99, en=1, up=1 → the next tick gives bcd_out = 8'h00 with wrap and tick_out high for one cycle.
- Down wrap (macro defined): load 8'h00, up=0 → next tick gives 8'h99 with wrap high. Next tick gives 8'h98 with wrap low.
- Priority: assert clear and load together in a tick cycle → bcd_out = 0, and tick_out and wrap stay 0.
- Load saturation: load_bcd = 8'hA3 → bcd_out = 8'h93, ascii_out = {7'h39,7'h33}.
- Enable freeze and async reset: drop en for 5 cycles mid-period → the next tick is delayed by exactly 5 cycles. Then pulse reset_n low between edges → outputs return to reset values immediately.
